// File: rtl/calc_sequencer_if.sv
// Key-event, ALU handshake and display/status bundle of the calculator sequencer.
// The master modport is the sequencer side; the slave modport is keypad/ALU/display.
interface calc_sequencer_if #(
  parameter int WIDTH = 12
);
  logic             key_valid;
  logic [3:0]       key_code;
  logic             alu_start;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_done;
  logic [WIDTH-1:0] alu_result;
  logic             alu_err;
  logic [WIDTH-1:0] display_value;
  logic [2:0]       input_state;
  logic             complete;
  logic             error;

  modport master (
    input  key_valid, key_code, alu_done, alu_result, alu_err,
    output alu_start, alu_op, alu_a, alu_b, display_value, input_state, complete, error
  );

  modport slave (
    output key_valid, key_code, alu_done, alu_result, alu_err,
    input  alu_start, alu_op, alu_a, alu_b, display_value, input_state, complete, error
  );
endinterface

// File: rtl/calc_sequencer.sv
// Calculator control FSM: gathers two decimal operands and an operator from key events,
// runs a start/done handshake with the ALU and registers the display and status outputs.
module calc_sequencer #(
  parameter int WIDTH       = 12,
  parameter int MAX_DIGITS  = 3,
  parameter int ALU_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              nRST,
  calc_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    ST_ENTER_A = 3'd0,
    ST_ENTER_B = 3'd1,
    ST_EXEC    = 3'd2,
    ST_RESULT  = 3'd3,
    ST_ERROR   = 3'd4
  } state_e;

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam int TMO_W = $clog2(ALU_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_DIGITS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(ALU_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);
  localparam logic [WIDTH-1:0] TEN       = WIDTH'(4'd10);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d, display_q, display_d;
  logic [CNT_W-1:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [1:0]       op_q, op_d;
  logic             start_q, start_d, complete_q, complete_d, error_q, error_d;

  logic             is_digit_s, is_op_s, is_clear_s, is_equals_s;
  logic [1:0]       key_op_s;
  logic [WIDTH-1:0] digit_s, a_shift_s, b_shift_s;

  // Classify the incoming key event
  always_comb begin
    is_digit_s  = 1'b0;
    is_op_s     = 1'b0;
    is_clear_s  = 1'b0;
    is_equals_s = 1'b0;
    key_op_s    = 2'b00;
    if (bus.key_valid) begin
      case (bus.key_code)
        4'hA:    begin is_op_s = 1'b1; key_op_s = 2'b00; end
        4'hB:    begin is_op_s = 1'b1; key_op_s = 2'b01; end
        4'hC:    begin is_op_s = 1'b1; key_op_s = 2'b10; end
        4'hD:    begin is_op_s = 1'b1; key_op_s = 2'b11; end
        4'hE:    is_clear_s  = 1'b1;
        4'hF:    is_equals_s = 1'b1;
        default: is_digit_s  = 1'b1;
      endcase
    end else begin
      is_digit_s = 1'b0;
    end
  end

  assign digit_s   = {{(WIDTH-4){1'b0}}, bus.key_code};
  assign a_shift_s = (a_q * TEN) + digit_s;
  assign b_shift_s = (b_q * TEN) + digit_s;

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    a_cnt_d  = a_cnt_q;
    b_cnt_d  = b_cnt_q;
    result_d = result_q;
    op_d     = op_q;
    tmo_d    = tmo_q;
    if (is_clear_s) begin
      state_d  = ST_ENTER_A;
      a_d      = '0;
      b_d      = '0;
      a_cnt_d  = '0;
      b_cnt_d  = '0;
      result_d = '0;
      op_d     = 2'b00;
      tmo_d    = '0;
    end else begin
      case (state_q)
        ST_ENTER_A: begin
          if (is_digit_s && (a_cnt_q < MAX_CNT)) begin
            a_d     = a_shift_s;
            a_cnt_d = a_cnt_q + CNT_ONE;
          end else if (is_op_s) begin
            op_d    = key_op_s;
            b_d     = '0;
            b_cnt_d = '0;
            state_d = ST_ENTER_B;
          end else begin
            state_d = ST_ENTER_A;
          end
        end
        ST_ENTER_B: begin
          if (is_digit_s && (b_cnt_q < MAX_CNT)) begin
            b_d     = b_shift_s;
            b_cnt_d = b_cnt_q + CNT_ONE;
          end else if (is_op_s && (b_cnt_q == '0)) begin
            op_d = key_op_s;
          end else if (is_equals_s && (b_cnt_q != '0)) begin
            tmo_d   = '0;
            state_d = ST_EXEC;
          end else begin
            state_d = ST_ENTER_B;
          end
        end
        ST_EXEC: begin
          tmo_d = tmo_q + TMO_ONE;
          if (bus.alu_done) begin
            if (bus.alu_err) begin
              state_d = ST_ERROR;
            end else begin
              result_d = bus.alu_result;
              state_d  = ST_RESULT;
            end
          end else if ((tmo_q + TMO_ONE) == TMO_LIMIT) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_EXEC;
          end
        end
        ST_RESULT: begin
          if (is_digit_s) begin
            a_d     = digit_s;
            a_cnt_d = CNT_ONE;
            b_d     = '0;
            b_cnt_d = '0;
            state_d = ST_ENTER_A;
          end else if (is_op_s) begin
            // Chaining: the previous result becomes a full, closed operand A
            a_d     = result_q;
            a_cnt_d = MAX_CNT;
            op_d    = key_op_s;
            b_d     = '0;
            b_cnt_d = '0;
            state_d = ST_ENTER_B;
          end else begin
            state_d = ST_RESULT;
          end
        end
        ST_ERROR: state_d = ST_ERROR;
        default:  state_d = ST_ENTER_A;
      endcase
    end
  end

  // Registered outputs derived from the upcoming state
  always_comb begin
    start_d    = (state_d == ST_EXEC) && (state_q != ST_EXEC);
    complete_d = (state_d == ST_RESULT);
    error_d    = (state_d == ST_ERROR);
    display_d  = display_q;
    case (state_d)
      ST_ENTER_A: display_d = a_d;
      ST_ENTER_B: display_d = (b_cnt_d != '0) ? b_d : a_d;
      ST_EXEC:    display_d = display_q;
      ST_RESULT:  display_d = result_d;
      ST_ERROR:   display_d = '0;
      default:    display_d = '0;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q    <= ST_ENTER_A;
      a_q        <= '0;
      b_q        <= '0;
      a_cnt_q    <= '0;
      b_cnt_q    <= '0;
      result_q   <= '0;
      op_q       <= 2'b00;
      tmo_q      <= '0;
      display_q  <= '0;
      start_q    <= 1'b0;
      complete_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      a_cnt_q    <= a_cnt_d;
      b_cnt_q    <= b_cnt_d;
      result_q   <= result_d;
      op_q       <= op_d;
      tmo_q      <= tmo_d;
      display_q  <= display_d;
      start_q    <= start_d;
      complete_q <= complete_d;
      error_q    <= error_d;
    end
  end

  assign bus.alu_start     = start_q;
  assign bus.alu_op        = op_q;
  assign bus.alu_a         = a_q;
  assign bus.alu_b         = b_q;
  assign bus.display_value = display_q;
  assign bus.input_state   = state_q;
  assign bus.complete      = complete_q;
  assign bus.error         = error_q;

endmodule
